zstr_fifo_reg: RTL and testbench
================================

# zstr_fifo_reg

Single-clock, register-array FIFO for the zstr valid/acknowledge stream protocol. It decouples a zstr producer (input side `zi_*`) from a zstr consumer (output side `zo_*`) by buffering up to LN words of BW bits. It sits between stream sources and sinks inside one clock domain and serves as the synchronous counterpart of the dual-clock register FIFO.

## Interface
- `BW`, 8: data bus width in bits.
- `LN`, 4: FIFO depth in words; power of two, ≥ 2.

Ports:
- `z_clk`  in  1: clock, rising edge.
- `z_rst`  in  1: reset; one clock, asynchronous assert, active-low.
- `zi_vld`  in  1: input word valid.
- `zi_bus`  in  BW: input data.
- `zi_ack`  out  1: FIFO can accept a word (not full).
- `zo_vld`  out  1: output word valid (not empty).
- `zo_bus`  out  BW: output data, the head of the FIFO.
- `zo_ack`  in  1: consumer accepts the output word.
- `z_cnt`  out  clog2(LN)+1: current occupancy, 0..LN.

## Operation
- Transfer rule on each port: a word moves when `vld & ack` is high at the rising edge. The input-side transfer is `zi_trn = zi_vld & zi_ack`; the output-side transfer is `zo_trn = zo_vld & zo_ack`.
- Storage: `mem[0:LN-1]` of BW bits. Write pointer `wp` and read pointer `rp` are each clog2(LN)+1 bits wide; the MSB is a wrap bit.
- On `zi_trn`: `mem[wp[AW-1:0]] <= zi_bus` and `wp <= wp+1`. On `zo_trn`: `rp <= rp+1`. Pointers wrap modulo 2·LN.
- Empty when `wp == rp`. Full when the low bits are equal and the wrap bits differ.
- `zi_ack = !full`. `zo_vld = !empty`. `zo_bus = mem[rp[AW-1:0]]`, read combinationally. `z_cnt = wp - rp`.
- Ordering is strict FIFO. No word is dropped or duplicated.
- Full with `zo_trn` in the same cycle: no write occurs, because `zi_ack` is low. `zi_ack` rises on the next cycle.
- Empty with `zi_vld`: no bypass. The word is written and becomes visible the following cycle.
- Non-full and non-empty with both transfers in the same cycle: both happen, and the count is unchanged.
- Reset, asynchronous low, at any time including mid-stream:
  - `wp = rp = 0`, giving `zo_vld = 0`, `zi_ack = 1`, `z_cnt = 0`.
  - Buffered contents are discarded.
  - `mem` is not reset. `zo_bus` is don't-care while `zo_vld = 0`.
- Ignored inputs: `zi_bus` is ignored when `zi_trn` is low. `zo_ack` is ignored when `zo_vld` is low.

## Timing
- Latency: a word written at edge k appears on `zo_vld`/`zo_bus` after edge k, so it is consumable at edge k+1.
- `zi_ack` and `zo_vld` depend only on registered state. There is no combinational path from `zo_ack` to `zi_ack`, or from `zi_vld` to `zo_vld`.
- While `zo_vld & !zo_ack`, `zo_bus` holds stable.
- Throughput: one word per cycle sustained, with a continuously valid source and a continuously ready sink.
- Release of `z_rst`: the first transfer can occur at the first rising edge after release. The release must be synchronous to `z_clk`; this is handled externally.

## Structure
- A shared zstr package holds the protocol-wide defaults `BW = 8` and the transfer-condition helper.
- `AW = clog2(LN)` is a local derived constant.
- Single flat module, no sub-modules. The pointer/flag logic is small enough to stay inline.

## Test plan
- Streaming: source sends 0..18 back-to-back, sink acks every cycle.
  - Sink receives 0..18 in order.
  - `zi_ack` never drops.
  - Each word appears 1 cycle after its write.
- Fill/back-pressure: `zo_ack = 0`, source sends 0..5.
  - `z_cnt` counts 1,2,3,4.
  - `zi_ack` goes low after the 4th word; words 4 and 5 are held at the source.
  - `zo_bus = 0` held stable.
- Drain while full: raise `zo_ack` for one cycle with the FIFO full.
  - Word 0 is read.
  - `zi_ack` rises the next cycle, then word 4 enters.
  - Final output order is 0..5.
- Wrap-around: push and pop 3·LN words with random `zi_vld`/`zo_ack` gaps.
  - Output order equals input order.
  - `z_cnt` stays within 0..4 and is never above LN.
- Simultaneous read and write at `z_cnt = 2`: both transfers occur and `z_cnt` stays at 2.
- Mid-operation reset: with 3 words buffered, pulse `z_rst` low between clock edges.
  - Immediately `zo_vld = 0`, `zi_ack = 1`, `z_cnt = 0`.
  - The next word sent after release is the first word out.

Source files
------------

// File: rtl/zstr_fifo_reg_pkg.sv
// zstr_fifo_reg_pkg: protocol-wide zstr stream defaults and the transfer-condition helper
package zstr_fifo_reg_pkg;
  localparam int ZSTR_BW = 8;
  function automatic logic zstr_trn(input logic vld, input logic ack);
    return vld & ack;
  endfunction
endpackage

// File: rtl/zstr_fifo_reg.sv
// zstr_fifo_reg: single-clock register-array FIFO between a zstr producer and consumer
module zstr_fifo_reg
  import zstr_fifo_reg_pkg::*;
#(
  parameter int BW = ZSTR_BW,
  parameter int LN = 4
) (
  input  logic                 z_clk,
  input  logic                 z_rst,
  input  logic                 zi_vld,
  input  logic [BW-1:0]        zi_bus,
  output logic                 zi_ack,
  output logic                 zo_vld,
  output logic [BW-1:0]        zo_bus,
  input  logic                 zo_ack,
  output logic [$clog2(LN):0]  z_cnt
);
  localparam int AW = $clog2(LN);
  logic [BW-1:0] r_mem [LN];
  logic [AW:0]   r_wp, r_rp;
  logic          w_full, w_empty, w_zi_trn, w_zo_trn;
  // flags come only from registered pointers, so no ack/vld combinational feedthrough
  always_comb begin
    w_empty  = r_wp == r_rp;
    w_full   = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    zi_ack   = !w_full;
    zo_vld   = !w_empty;
    w_zi_trn = zstr_trn(zi_vld, zi_ack);
    w_zo_trn = zstr_trn(zo_vld, zo_ack);
    zo_bus   = r_mem[r_rp[AW-1:0]];
    z_cnt    = r_wp - r_rp;
  end
  // pointers carry a wrap bit so full and empty are distinguishable; reset discards contents
  always_ff @(posedge z_clk or negedge z_rst) begin
    if (!z_rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_zi_trn) r_wp <= r_wp + 1'b1;
      if (w_zo_trn) r_rp <= r_rp + 1'b1;
    end
  end
  // storage is not reset; its content is meaningless until written
  always_ff @(posedge z_clk) begin
    if (w_zi_trn) r_mem[r_wp[AW-1:0]] <= zi_bus;
  end
endmodule

// File: tb/tb_zstr_fifo_reg.sv
// tb_zstr_fifo_reg: directed and randomized checks of zstr_fifo_reg against a queue model
module tb_zstr_fifo_reg;
  localparam int BW = 8;
  localparam int LN = 4;
  logic          z_clk = 1'b0;
  logic          z_rst = 1'b0;
  logic          zi_vld = 1'b0;
  logic [BW-1:0] zi_bus = '0;
  logic          zi_ack;
  logic          zo_vld;
  logic [BW-1:0] zo_bus;
  logic          zo_ack = 1'b0;
  logic [2:0]    z_cnt;
  int vectors = 0;
  int miscompares = 0;
  logic [BW-1:0] q[$];
  zstr_fifo_reg #(.BW(BW), .LN(LN)) dut (
    .z_clk(z_clk), .z_rst(z_rst),
    .zi_vld(zi_vld), .zi_bus(zi_bus), .zi_ack(zi_ack),
    .zo_vld(zo_vld), .zo_bus(zo_bus), .zo_ack(zo_ack),
    .z_cnt(z_cnt)
  );
  always #5 z_clk = ~z_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_outputs();
    chk("zi_ack", 32'(zi_ack), 32'(q.size() < LN));
    chk("zo_vld", 32'(zo_vld), 32'(q.size() != 0));
    chk("z_cnt", 32'(z_cnt), 32'(q.size()));
    if (q.size() != 0) chk("zo_bus", 32'(zo_bus), 32'(q[0]));
  endtask
  task automatic cyc(input logic v, input logic [BW-1:0] d, input logic a,
                     output logic acc, output logic pop);
    zi_vld = v; zi_bus = d; zo_ack = a;
    #1;
    chk_outputs();
    acc = v && (q.size() < LN);
    pop = a && (q.size() != 0);
    @(posedge z_clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(d);
    @(negedge z_clk);
  endtask
  initial begin
    logic acc, pop;
    int n, outs, guard;
    z_rst = 1'b0;
    repeat (2) @(negedge z_clk);
    #1;
    chk("rst_zo_vld", 32'(zo_vld), 32'd0);
    chk("rst_zi_ack", 32'(zi_ack), 32'd1);
    chk("rst_z_cnt", 32'(z_cnt), 32'd0);
    @(negedge z_clk);
    z_rst = 1'b1;
    n = 0;
    while (n < 19) begin
      cyc(1'b1, BW'(n), 1'b1, acc, pop);
      chk("stream_accept", 32'(acc), 32'd1);
      if (acc) n++;
    end
    cyc(1'b0, '0, 1'b1, acc, pop);
    chk("stream_drained", 32'(q.size()), 32'd0);
    n = 0;
    repeat (6) begin
      cyc(1'b1, BW'(n), 1'b0, acc, pop);
      if (acc) n++;
    end
    chk("fill_held_at_src", 32'(n), 32'd4);
    chk("fill_zo_bus", 32'(zo_bus), 32'd0);
    cyc(1'b1, BW'(n), 1'b1, acc, pop);
    chk("full_no_write", 32'(acc), 32'd0);
    chk("full_popped", 32'(pop), 32'd1);
    cyc(1'b1, BW'(n), 1'b0, acc, pop);
    chk("word4_enters", 32'(acc), 32'd1);
    if (acc) n++;
    guard = 0;
    while (n < 6 && guard < 20) begin
      cyc(1'b1, BW'(n), 1'b1, acc, pop);
      if (acc) n++;
      guard++;
    end
    chk("word5_sent", 32'(n), 32'd6);
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      cyc(1'b0, '0, 1'b1, acc, pop);
      guard++;
    end
    chk("fill_drained", 32'(q.size()), 32'd0);
    n = 0; outs = 0; guard = 0;
    while ((n < 3 * LN || q.size() != 0) && guard < 500) begin
      cyc(n < 3 * LN && $urandom_range(0, 2) != 0, BW'($urandom), $urandom_range(0, 1) == 1, acc, pop);
      if (acc) n++;
      if (pop) outs++;
      chk("wrap_cnt_le_ln", 32'(z_cnt <= LN), 32'd1);
      guard++;
    end
    chk("wrap_out_count", 32'(outs), 32'(3 * LN));
    cyc(1'b1, 8'hA1, 1'b0, acc, pop);
    cyc(1'b1, 8'hA2, 1'b0, acc, pop);
    cyc(1'b1, 8'hA3, 1'b1, acc, pop);
    chk("simul_both", 32'({acc, pop}), 32'b11);
    #1;
    chk("simul_cnt", 32'(z_cnt), 32'd2);
    cyc(1'b1, 8'hA4, 1'b0, acc, pop);
    chk("pre_rst_cnt", 32'(z_cnt), 32'd3);
    zi_vld = 1'b0; zo_ack = 1'b0;
    #2 z_rst = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_zo_vld", 32'(zo_vld), 32'd0);
    chk("mid_rst_zi_ack", 32'(zi_ack), 32'd1);
    chk("mid_rst_z_cnt", 32'(z_cnt), 32'd0);
    #1 z_rst = 1'b1;
    @(negedge z_clk);
    cyc(1'b1, 8'h5C, 1'b0, acc, pop);
    chk("post_rst_first", 32'(zo_bus), 32'h5C);
    cyc(1'b0, '0, 1'b1, acc, pop);
    cyc(1'b0, '0, 1'b0, acc, pop);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
